// File: rtl/mul_5bits_j5.sv
// Unsigned 5x5 carry-save array multiplier with registered 10-bit product.
// Define MUL5_PIPE_EN to register the CSA outputs before the ripple adder (latency 2 instead of 1).

module mul5_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module mul5_ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic co
);
    assign s  = a ^ b;
    assign co = a & b;
endmodule

// One carry-save row: adds a shifted partial-product row to the running sum/carry.
module mul5_csa_row (
    input  logic [4:0] pp_row,
    input  logic [3:0] sum_in,
    input  logic [3:0] carry_in,
    output logic [4:0] sum_out,
    output logic [3:0] carry_out
);
    for (genvar j = 0; j < 4; j++) begin : g_fa
        mul5_fa u_fa (
            .a  (pp_row[j]),
            .b  (sum_in[j]),
            .ci (carry_in[j]),
            .s  (sum_out[j]),
            .co (carry_out[j])
        );
    end
    assign sum_out[4] = pp_row[4];
endmodule

// No handshake: an operand pair is accepted on every rising edge and its
// product appears on s a fixed number of edges later.
module mul_5bits_j5 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] a,
    input  logic [4:0] b,
    output logic [9:0] s
);
    logic [4:0] pp [5];
    logic [4:0] sum1, sum2, sum3, sum4;
    logic [3:0] carry1, carry2, carry3, carry4;
    logic [4:0] low_bits;

    // Column-wise bit sum*_x[j] has weight (row + j); carry*_x[j] has weight (row + j + 1).
    for (genvar i = 0; i < 5; i++) begin : g_pp
        assign pp[i] = a & {5{b[i]}};
    end

    for (genvar j = 0; j < 4; j++) begin : g_row1
        mul5_ha u_ha (
            .a  (pp[0][j+1]),
            .b  (pp[1][j]),
            .s  (sum1[j]),
            .co (carry1[j])
        );
    end
    assign sum1[4] = pp[1][4];

    mul5_csa_row u_row2 (
        .pp_row    (pp[2]),
        .sum_in    (sum1[4:1]),
        .carry_in  (carry1),
        .sum_out   (sum2),
        .carry_out (carry2)
    );

    mul5_csa_row u_row3 (
        .pp_row    (pp[3]),
        .sum_in    (sum2[4:1]),
        .carry_in  (carry2),
        .sum_out   (sum3),
        .carry_out (carry3)
    );

    mul5_csa_row u_row4 (
        .pp_row    (pp[4]),
        .sum_in    (sum3[4:1]),
        .carry_in  (carry3),
        .sum_out   (sum4),
        .carry_out (carry4)
    );

    assign low_bits = {sum4[0], sum3[0], sum2[0], sum1[0], pp[0][0]};

    logic [3:0] stg_sum;
    logic [3:0] stg_carry;
    logic [4:0] stg_low;

`ifdef MUL5_PIPE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg_sum   <= '0;
            stg_carry <= '0;
            stg_low   <= '0;
        end else begin
            stg_sum   <= sum4[4:1];
            stg_carry <= carry4;
            stg_low   <= low_bits;
        end
    end
`else
    assign stg_sum   = sum4[4:1];
    assign stg_carry = carry4;
    assign stg_low   = low_bits;
`endif

    // Ripple carry-propagate adder producing weights 5..9.
    logic [4:0] hi_bits;
    logic       c6, c7, c8;

    mul5_ha u_cpa0 (.a(stg_sum[0]), .b(stg_carry[0]),            .s(hi_bits[0]), .co(c6));
    mul5_fa u_cpa1 (.a(stg_sum[1]), .b(stg_carry[1]), .ci(c6),   .s(hi_bits[1]), .co(c7));
    mul5_fa u_cpa2 (.a(stg_sum[2]), .b(stg_carry[2]), .ci(c7),   .s(hi_bits[2]), .co(c8));
    mul5_fa u_cpa3 (.a(stg_sum[3]), .b(stg_carry[3]), .ci(c8),   .s(hi_bits[3]), .co(hi_bits[4]));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s <= '0;
        end else begin
            s <= {hi_bits, stg_low};
        end
    end
endmodule

// File: tb/tb_mul_5bits_j5.sv
// Self-checking bench for mul_5bits_j5: directed, exhaustive and random operands
// against a queue-based product model; honours MUL5_PIPE_EN for latency.

module tb_mul_5bits_j5;
`ifdef MUL5_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       rst_n;
    logic [4:0] a;
    logic [4:0] b;
    logic [9:0] s;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [9:0] exp_q[$];
    logic [9:0] pipe_q[$];

    mul_5bits_j5 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .s     (s)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst_n = 1'b0;
        a     = 5'd31;
        b     = 5'd31;
    end

    // Reference model: products travel through a LAT-deep delay line; a reset
    // edge empties it and forces the output to zero.
    always @(posedge clk) begin
        if (!rst_n) begin
            pipe_q.delete();
            for (int k = 0; k < LAT - 1; k++) pipe_q.push_back(10'd0);
            exp_q.push_back(10'd0);
        end else begin
            pipe_q.push_back(10'(int'(a) * int'(b)));
            exp_q.push_back(pipe_q.pop_front());
        end
    end

    // Monitor: the product register updates every edge, so one check per edge.
    always @(posedge clk) begin
        logic [9:0] exp_v;
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (s !== exp_v) begin
                n_fail++;
                $display("FAIL product at %0t: got %0d, expected %0d", $time, s, exp_v);
            end
        end
    end

    // driver
    task automatic drive(input logic [4:0] av, input logic [4:0] bv, input logic rv);
        @(negedge clk);
        a     = av;
        b     = bv;
        rst_n = rv;
    endtask

    initial begin
        logic [4:0] ca [6];
        logic [4:0] cb [6];
        ca = '{5'd0, 5'd31, 5'd1, 5'd31, 5'd31, 5'd16};
        cb = '{5'd31, 5'd0, 5'd31, 5'd1, 5'd31, 5'd16};

        // reset with max operands, then release
        repeat (3) drive(5'd31, 5'd31, 1'b0);
        repeat (3) drive(5'd31, 5'd31, 1'b1);

        // basic
        drive(5'd5, 5'd3, 1'b1);
        drive(5'd7, 5'd9, 1'b1);

        // corners, each held for a few cycles
        for (int k = 0; k < 6; k++) begin
            repeat (3) drive(ca[k], cb[k], 1'b1);
        end

        // streaming, with a one-edge reset in the middle of a second stream
        for (int i = 0; i < 10; i++) drive(5'(i), 5'(31 - i), 1'b1);
        for (int i = 0; i < 10; i++) drive(5'(i + 3), 5'(20 - i), (i == 4) ? 1'b0 : 1'b1);

        // exhaustive
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 32; j++) drive(5'(i), 5'(j), 1'b1);
        end

        // random with occasional reset pulses
        for (int k = 0; k < 300; k++) begin
            drive(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 24) == 0) ? 1'b0 : 1'b1);
        end

        repeat (LAT + 2) drive(5'd0, 5'd0, 1'b1);
        @(negedge clk);

        n_cmp++;
        if (n_cmp < 1300) begin
            n_fail++;
            $display("FAIL check_count: got %0d checks, expected at least 1300", n_cmp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
